// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store controller for a single-port word memory.
// Sub-word stores use read-modify-write; sub-word loads are lane-selected and extended.
module dmem_access_ctrl #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [5:0]    req_opcode,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [5:0]    r_op;
   logic [1:0]    r_lane;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_legal;
   logic          w_misal;
   logic          w_reqErr;
   logic          w_accept;
   logic          w_isLoad;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_loadData;
   logic [31:0]   w_merged;

   // Request screening: illegal opcode, then out-of-range address, then misalignment.
   always_comb begin
      w_legal = 1'b1;
      w_misal = 1'b0;
      case (req_opcode)
         OP_LB, OP_LBU, OP_SB: w_misal = 1'b0;
         OP_LH, OP_LHU, OP_SH: w_misal = req_addr[0];
         OP_LW, OP_SW:         w_misal = |req_addr[1:0];
         default:              w_legal = 1'b0;
      endcase
      w_reqErr = !w_legal || ((req_addr >> (AW + 2)) != 32'd0) || w_misal;
   end

   assign w_accept = (r_state == S_IDLE) && req_valid;

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_reqErr)                w_next = S_RESP;
               else if (req_opcode == OP_SW) w_next = S_WR;
               else                          w_next = S_RD;
            end
         end
         S_RD: begin
            mem_en = 1'b1;
            w_next = S_WAIT;
         end
         S_WAIT: w_next = w_isLoad ? S_RESP : S_WR;
         S_WR: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            w_next = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Little-endian lane extraction for loads and lane insertion for sub-word stores.
   always_comb begin
      w_isLoad   = 1'b0;
      w_loadData = 32'd0;
      w_merged   = mem_rdata;
      w_byte     = mem_rdata[7:0];
      case (r_lane)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_op)
         OP_LB: begin
            w_isLoad   = 1'b1;
            w_loadData = {{24{w_byte[7]}}, w_byte};
         end
         OP_LBU: begin
            w_isLoad   = 1'b1;
            w_loadData = {24'd0, w_byte};
         end
         OP_LH: begin
            w_isLoad   = 1'b1;
            w_loadData = {{16{w_half[15]}}, w_half};
         end
         OP_LHU: begin
            w_isLoad   = 1'b1;
            w_loadData = {16'd0, w_half};
         end
         OP_LW: begin
            w_isLoad   = 1'b1;
            w_loadData = mem_rdata;
         end
         OP_SB: begin
            case (r_lane)
               2'd0: w_merged[7:0]   = r_wdata[7:0];
               2'd1: w_merged[15:8]  = r_wdata[7:0];
               2'd2: w_merged[23:16] = r_wdata[7:0];
               2'd3: w_merged[31:24] = r_wdata[7:0];
               default: w_merged = mem_rdata;
            endcase
         end
         OP_SH: begin
            if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
         end
         default: w_isLoad = 1'b0;
      endcase
   end

   // r_wdata doubles as the write word: raw store data for sw, merged word for sb/sh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op    <= 6'd0;
         r_lane  <= 2'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_op    <= req_opcode;
         r_lane  <= req_addr[1:0];
         r_addr  <= req_addr[AW+1:2];
         r_wdata <= req_wdata;
         r_rdata <= 32'd0;
         r_err   <= w_reqErr;
      end else if (r_state == S_WAIT) begin
         if (w_isLoad) r_rdata <= w_loadData;
         else          r_wdata <= w_merged;
      end else if ((r_state == S_RESP) && rsp_ready) begin
         r_err <= 1'b0;
      end
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a request-level reference model predicts
// every cycle's handshake and memory-port activity; directed cases pin known values.
module tb_dmem_access_ctrl;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [5:0]    req_opcode;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] envMem [0:255];
   logic [31:0] refMem [0:255];

   bit          mActive;
   int          mK, mLat, mReadK, mWriteK;
   logic [AW-1:0] mAddr;
   logic [31:0] mWData, mRdata;
   logic        mErr;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_access_ctrl #(.AW(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] memInit(int i);
      return (i == 0) ? 32'h8070F0A5 : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Request-level model: decides the outcome from opcode/address rules and a plain word array.
   function automatic void modelAccept(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
      int size;
      bit legal;
      int sh;
      logic [31:0] word;
      legal   = 1;
      size    = 1;
      case (op)
         6'h20, 6'h24, 6'h28: size = 1;
         6'h21, 6'h25, 6'h29: size = 2;
         6'h23, 6'h2B:        size = 4;
         default:             legal = 0;
      endcase
      mRdata  = 32'd0;
      mWData  = 32'd0;
      mReadK  = -1;
      mWriteK = -1;
      mAddr   = addr[AW+1:2];
      if (!legal || ((addr >> (AW + 2)) != 0) || ((addr % size) != 0)) begin
         mErr = 1'b1;
         mLat = 1;
         return;
      end
      mErr   = 1'b0;
      word   = refMem[mAddr];
      sh     = 8 * int'(addr % 4);
      mLat   = 3;
      mReadK = 1;
      case (op)
         6'h20: begin
            mRdata = (word >> sh) & 32'hFF;
            if (mRdata >= 128) mRdata = mRdata - 32'd256;
         end
         6'h24: mRdata = (word >> sh) & 32'hFF;
         6'h21: begin
            mRdata = (word >> sh) & 32'hFFFF;
            if (mRdata >= 32768) mRdata = mRdata - 32'd65536;
         end
         6'h25: mRdata = (word >> sh) & 32'hFFFF;
         6'h23: mRdata = word;
         6'h2B: begin
            mLat    = 2;
            mReadK  = -1;
            mWriteK = 1;
            mWData  = wd;
         end
         6'h28: begin
            mLat    = 4;
            mWriteK = 3;
            mWData  = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
         end
         default: begin
            mLat    = 4;
            mWriteK = 3;
            mWData  = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
         end
      endcase
   endfunction

   // Memory environment: one-cycle read latency, writes land at the clock edge.
   initial begin
      for (int i = 0; i < 256; i++) envMem[i] <= memInit(i);
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_we) envMem[mem_addr] <= mem_wdata;
            else        mem_rdata <= envMem[mem_addr];
         end
      end
   end

   // Compare process: every negedge, DUT outputs against the model's expectations.
   initial begin
      bit expEn;
      for (int i = 0; i < 256; i++) refMem[i] = memInit(i);
      mActive = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            checkOutput("rstMemEn", mem_en, 0);
            checkOutput("rstRspValid", rsp_valid, 0);
            checkOutput("rstReqReady", req_ready, 1);
            checkOutput("rstRspErr", rsp_err, 0);
            mActive = 0;
         end else if (!mActive) begin
            checkOutput("idleReqReady", req_ready, 1);
            checkOutput("idleRspValid", rsp_valid, 0);
            checkOutput("idleMemEn", mem_en, 0);
            checkOutput("idleRspErr", rsp_err, 0);
            if (req_valid) begin
               modelAccept(req_opcode, req_addr, req_wdata);
               mActive = 1;
               mK = 0;
            end
         end else begin
            mK++;
            expEn = (mK == mReadK) || (mK == mWriteK);
            checkOutput("memEn", mem_en, expEn);
            if (expEn) begin
               checkOutput("memWe", mem_we, (mK == mWriteK));
               checkOutput("memAddr", mem_addr, mAddr);
            end
            if (mK == mWriteK) begin
               checkOutput("memWdata", mem_wdata, mWData);
               refMem[mAddr] = mWData;
            end
            checkOutput("busyReqReady", req_ready, 0);
            checkOutput("rspValid", rsp_valid, (mK >= mLat));
            if (mK >= mLat) begin
               checkOutput("rspRdata", rsp_rdata, mRdata);
               checkOutput("rspErr", rsp_err, mErr);
               if (rsp_ready) mActive = 0;
            end
         end
      end
   end

   // One request: present, wait for accept, wait for response, hold off 'hold' cycles, complete.
   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input int hold, output logic [31:0] rdata, output logic err, output int lat);
      bit accepted;
      bit got;
      int tAcc;
      accepted = 0;
      got      = 0;
      tAcc     = 0;
      rdata    = 32'd0;
      err      = 1'b0;
      lat      = 0;
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_opcode = op;
      req_addr   = addr;
      req_wdata  = wdata;
      for (int n = 0; n < 20 && !accepted; n++) begin
         if (req_ready) begin
            accepted = 1;
            tAcc = cyc;
         end else begin
            @(posedge clk); #1;
         end
      end
      checkOutput("acceptWait", accepted, 1);
      @(posedge clk); #1;
      req_valid = (hold > 0);
      for (int n = 0; n < 20 && !got; n++) begin
         if (rsp_valid) begin
            got   = 1;
            lat   = cyc - tAcc;
            rdata = rsp_rdata;
            err   = rsp_err;
         end else begin
            @(posedge clk); #1;
         end
      end
      checkOutput("rspWait", got, 1);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("reqReadyAfterRsp", req_ready, 1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lt;
      logic [5:0]  ops [0:7];
      logic [5:0]  op;
      logic [31:0] addr;
      ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_opcode = 6'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstRdata", rsp_rdata, 0);
      checkOutput("rstMemAddr", mem_addr, 0);
      checkOutput("rstMemWdata", mem_wdata, 0);
      checkOutput("rstMemWe", mem_we, 0);
      reset = 1'b0;

      applyStimulus(6'h20, 32'h0, 32'h0, 0, rd, er, lt);
      checkOutput("lbData", rd, 32'hFFFFFFA5);
      checkOutput("lbLat", 32'(lt), 3);
      applyStimulus(6'h24, 32'h0, 32'h0, 0, rd, er, lt);
      checkOutput("lbuData", rd, 32'h000000A5);
      applyStimulus(6'h21, 32'h2, 32'h0, 0, rd, er, lt);
      checkOutput("lhData", rd, 32'hFFFF8070);
      applyStimulus(6'h25, 32'h2, 32'h0, 1, rd, er, lt);
      checkOutput("lhuData", rd, 32'h00008070);
      checkOutput("lhuLat", 32'(lt), 3);

      applyStimulus(6'h28, 32'h1, 32'hDEADBE3C, 0, rd, er, lt);
      checkOutput("sbLat", 32'(lt), 4);
      checkOutput("sbRdata", rd, 0);
      checkOutput("sbErr", er, 0);
      checkOutput("sbMemWord", envMem[0], 32'h80703CA5);
      applyStimulus(6'h23, 32'h0, 32'h0, 5, rd, er, lt);
      checkOutput("lwAfterSb", rd, 32'h80703CA5);

      applyStimulus(6'h2B, 32'h0, 32'h8070F0A5, 0, rd, er, lt);
      applyStimulus(6'h29, 32'h2, 32'h00001234, 0, rd, er, lt);
      checkOutput("shMemWord", envMem[0], 32'h1234F0A5);
      checkOutput("shLat", 32'(lt), 4);
      applyStimulus(6'h2B, 32'h3FC, 32'hCAFEF00D, 0, rd, er, lt);
      checkOutput("swLat", 32'(lt), 2);
      checkOutput("swMemWord", envMem[255], 32'hCAFEF00D);

      applyStimulus(6'h23, 32'h6, 32'h0, 0, rd, er, lt);
      checkOutput("errLwMisErr", er, 1);
      checkOutput("errLwMisLat", 32'(lt), 1);
      applyStimulus(6'h29, 32'h3, 32'h0, 0, rd, er, lt);
      checkOutput("errShMisErr", er, 1);
      applyStimulus(6'h2A, 32'h0, 32'h0, 0, rd, er, lt);
      checkOutput("errOpErr", er, 1);
      checkOutput("errOpRdata", rd, 0);
      applyStimulus(6'h23, 32'h400, 32'h0, 0, rd, er, lt);
      checkOutput("errRangeErr", er, 1);
      checkOutput("errRangeLat", 32'(lt), 1);

      // Reset asserted while an sb sits in its read-wait cycle.
      @(posedge clk); #1;
      checkOutput("rstMidAccept", req_ready, 1);
      req_valid  = 1'b1;
      req_opcode = 6'h28;
      req_addr   = 32'h1;
      req_wdata  = 32'h000000EE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("rstMidReqReady", req_ready, 1);
      checkOutput("rstMidRspValid", rsp_valid, 0);
      checkOutput("rstMidMemWord", envMem[0], 32'h1234F0A5);

      for (int n = 0; n < 300; n++) begin
         int k;
         k = $urandom_range(0, 8);
         op = (k == 8) ? 6'($urandom_range(0, 63)) : ops[k];
         addr = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
         applyStimulus(op, addr, 32'($urandom), $urandom_range(0, 3), rd, er, lt);
      end

      for (int i = 0; i < 256; i++) checkOutput("memFinal", envMem[i], refMem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
